// File: rtl/axi_wr_lane_ctrl.sv
// AXI4 write-channel controller: walks FIXED/INCR(/WRAP) beat addresses, masks WSTRB to the
// legal byte lanes and issues one registered write per beat. WRAP support: AXI_WRAP_BURST_EN.
module axi_wr_lane_ctrl #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [ID_W-1:0]   awid,
    input  logic              wvalid,
    output logic              wready,
    input  logic [63:0]       wdata,
    input  logic [7:0]        wstrb,
    input  logic              wlast,
    output logic              bvalid,
    input  logic              bready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be
);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [1:0]        r_size;
    logic [1:0]        r_burst;
    logic [ID_W-1:0]   r_id;
    logic              r_dec_err;
    logic              r_last_err;
    logic [ID_W-1:0]   r_bid;
    logic [1:0]        r_bresp;
    logic              r_mem_we;
    logic [ADDR_W-4:0] r_mem_addr;
    logic [63:0]       r_mem_wdata;
    logic [7:0]        r_mem_be;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_final;
    logic              w_last_bad;
    logic              w_dec_err;
    logic [3:0]        w_nbytes;
    logic [3:0]        w_lo;
    logic [3:0]        w_hi;
    logic [7:0]        w_window;
    logic [ADDR_W-1:0] w_align;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_next;

    assign awready    = (r_state == S_IDLE);
    assign wready     = (r_state == S_DATA);
    assign bvalid     = (r_state == S_RESP);
    assign bid        = r_bid;
    assign bresp      = r_bresp;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;

    assign w_aw_hs    = awvalid && (r_state == S_IDLE);
    assign w_w_hs     = wvalid && (r_state == S_DATA);
    assign w_final    = (r_cnt == r_len);
    assign w_last_bad = (wlast != w_final);

`ifdef AXI_WRAP_BURST_EN
    assign w_dec_err = (awsize > 3'd3) || (awburst == 2'd3) ||
                       ((awburst == 2'd2) && !((awlen == 8'd1) || (awlen == 8'd3) ||
                                               (awlen == 8'd7) || (awlen == 8'd15)));
`else
    assign w_dec_err = (awsize > 3'd3) || (awburst >= 2'd2);
`endif

    // Lane window runs from the byte offset up to the end of the size-aligned container.
    assign w_nbytes = 4'd1 << r_size;
    assign w_lo     = {1'b0, r_addr[2:0]};
    assign w_hi     = ({1'b0, r_addr[2:0]} & ~(w_nbytes - 4'd1)) + w_nbytes - 4'd1;

    always_comb begin
        w_window = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_window[i] = (4'(i) >= w_lo) && (4'(i) <= w_hi);
        end
    end

    assign w_align = r_addr & ~(ADDR_W'(w_nbytes) - ADDR_W'(1));
    assign w_incr  = w_align + ADDR_W'(w_nbytes);

`ifdef AXI_WRAP_BURST_EN
    logic [ADDR_W-1:0] w_wrap_bytes;
    logic [ADDR_W-1:0] w_wrap_base;
    logic [ADDR_W-1:0] w_wrap_next;

    // The base is re-derived from the current address, which always stays inside the window.
    assign w_wrap_bytes = (ADDR_W'(r_len) + ADDR_W'(1)) << r_size;
    assign w_wrap_base  = r_addr & ~(w_wrap_bytes - ADDR_W'(1));
    assign w_wrap_next  = (w_incr == (w_wrap_base + w_wrap_bytes)) ? w_wrap_base : w_incr;
`endif

    always_comb begin
        w_next = r_addr;
        case (r_burst)
            2'd1:    w_next = w_incr;
`ifdef AXI_WRAP_BURST_EN
            2'd2:    w_next = w_wrap_next;
`endif
            default: w_next = r_addr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_size      <= '0;
            r_burst     <= '0;
            r_id        <= '0;
            r_dec_err   <= 1'b0;
            r_last_err  <= 1'b0;
            r_bid       <= '0;
            r_bresp     <= 2'b00;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_aw_hs) begin
                        r_addr     <= awaddr;
                        r_len      <= awlen;
                        r_size     <= awsize[1:0];
                        r_burst    <= awburst;
                        r_id       <= awid;
                        r_cnt      <= '0;
                        r_dec_err  <= w_dec_err;
                        r_last_err <= 1'b0;
                        r_state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_w_hs) begin
                        if (!r_dec_err) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_addr[ADDR_W-1:3];
                            r_mem_wdata <= wdata;
                            r_mem_be    <= wstrb & w_window;
                        end
                        r_addr <= w_next;
                        r_cnt  <= r_cnt + 8'd1;
                        if (w_last_bad) begin
                            r_last_err <= 1'b1;
                        end
                        if (w_final) begin
                            r_bid   <= r_id;
                            r_bresp <= (r_dec_err || r_last_err || w_last_bad) ? 2'b10 : 2'b00;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (bready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_lane_ctrl.sv
// Bench for axi_wr_lane_ctrl: directed and random bursts, scoreboard queues fed by a
// burst-level reference model, monitor compares writes and B responses as they appear.
module tb_axi_wr_lane_ctrl;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int MW     = (ADDR_W - 3) + 64 + 8;
  localparam int BW     = ID_W + 2;
  localparam int TMO    = 50;
`ifdef AXI_WRAP_BURST_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [ID_W-1:0]   awid;
  logic              wvalid;
  logic              wready;
  logic [63:0]       wdata;
  logic [7:0]        wstrb;
  logic              wlast;
  logic              bvalid;
  logic              bready;
  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              mem_we;
  logic [ADDR_W-4:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_be;

  axi_wr_lane_ctrl #(.ADDR_W(ADDR_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst), .awid(awid),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [MW-1:0] exp_q[$];
  logic [BW-1:0] exp_b_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  bit            mon_en = 1'b0;
  bit            cur_dec_err = 1'b0;
  logic [7:0]    beat_strb[16];
  logic [63:0]   beat_data[16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_dec_err(int len, int size, int burst);
    if (size > 3 || burst == 3) return 1'b1;
    if (burst == 2) return !(WRAP_EN && (len == 1 || len == 3 || len == 7 || len == 15));
    return 1'b0;
  endfunction

  function automatic logic [31:0] beat_addr(logic [31:0] a, int len, int size, int burst, int k);
    logic [31:0] n, aligned, w, base;
    n       = 32'd1 << size;
    aligned = a - (a % n);
    if (k == 0 || burst == 0) return a;
    if (burst == 1) return aligned + n * 32'(k);
    w    = n * 32'(len + 1);
    base = a - (a % w);
    return base + ((aligned - base + n * 32'(k)) % w);
  endfunction

  function automatic logic [7:0] lanes(logic [31:0] a, int size);
    int n, lo, hi;
    logic [7:0] m;
    n  = 1 << size;
    lo = int'(a % 8);
    hi = (lo / n) * n + n - 1;
    m  = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = (i >= lo) && (i <= hi);
    return m;
  endfunction

  // ---------------- monitor ----------------
  bit prev_hs  = 1'b0;
  bit prev_rst = 1'b0;
  bit prev_de  = 1'b0;

  always @(negedge clk) begin
    logic [MW-1:0] e;
    logic [BW-1:0] eb;
    if (mon_en) begin
      chk("mem_we_timing", 128'(mem_we), 128'(prev_hs && !prev_de && !prev_rst));
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL mem_write: got unexpected write addr %0h expected none", mem_addr);
        end else begin
          e = exp_q.pop_front();
          chk("mem_write", 128'({mem_addr, mem_wdata, mem_be}), 128'(e));
        end
      end
      if (bvalid === 1'b1 && bready === 1'b1) begin
        if (exp_b_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_resp: got unexpected B %0h expected none", {bid, bresp});
        end else begin
          eb = exp_b_q.pop_front();
          chk("b_resp", 128'({bid, bresp}), 128'(eb));
        end
      end
    end
    prev_hs  = (wvalid === 1'b1) && (wready === 1'b1);
    prev_rst = (rst === 1'b1);
    prev_de  = cur_dec_err;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input string name, input int which);
    int t = 0;
    @(negedge clk);
    while (t < TMO && !((which == 0 && awready) || (which == 1 && wready) || (which == 2 && bvalid))) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) chk(name, 128'(0), 128'(1));
  endtask

  task automatic fill_rand_strb();
    for (int i = 0; i < 16; i++) begin
      beat_strb[i] = 8'($urandom);
      beat_data[i] = {$urandom, $urandom};
    end
  endtask

  task automatic do_burst(input logic [31:0] a, input int len, input int size, input int burst,
                          input int id, input int bad_beat, input bit gaps);
    bit de;
    bit last_err;
    logic [31:0] ba;
    de       = model_dec_err(len, size, burst);
    last_err = (bad_beat >= 0 && bad_beat <= len);
    if (!de) begin
      for (int k = 0; k <= len; k++) begin
        ba = beat_addr(a, len, size, burst, k);
        exp_q.push_back({ba[31:3], beat_data[k], beat_strb[k] & lanes(ba, size)});
      end
    end
    exp_b_q.push_back({4'(id), (de || last_err) ? 2'b10 : 2'b00});
    cur_dec_err = de;
    awvalid = 1'b1; awaddr = a; awlen = 8'(len); awsize = 3'(size);
    awburst = 2'(burst); awid = 4'(id);
    wvalid = 1'b1; wdata = beat_data[0]; wstrb = beat_strb[0];
    wlast = (len == 0) ^ (bad_beat == 0);
    wait_neg("aw_timeout", 0);
    chk("wready_in_idle", 128'(wready), 128'(0));
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if (gaps && k > 0) begin
        wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      wvalid = 1'b1; wdata = beat_data[k]; wstrb = beat_strb[k];
      wlast = (k == len) ^ (k == bad_beat);
      wait_neg("w_timeout", 1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0; wlast = 1'b0;
    @(negedge clk);
    chk("bvalid_after_last", 128'(bvalid), 128'(1));
    @(posedge clk); #1;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    bready = 1'b1;
    wait_neg("b_timeout", 2);
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
    chk("awready_after_b", 128'(awready), 128'(1));
    @(posedge clk); #1;
  endtask

  task automatic reset_mid_burst();
    for (int i = 0; i < 16; i++) begin beat_strb[i] = 8'hFF; beat_data[i] = {$urandom, $urandom}; end
    exp_q.push_back({29'h60, beat_data[0], 8'hFF});
    cur_dec_err = 1'b0;
    awvalid = 1'b1; awaddr = 32'h300; awlen = 8'd3; awsize = 3'd3; awburst = 2'd1; awid = 4'd9;
    wait_neg("aw_timeout", 0);
    @(posedge clk); #1;
    awvalid = 1'b0;
    wvalid = 1'b1; wdata = beat_data[0]; wstrb = 8'hFF; wlast = 1'b0;
    wait_neg("w_timeout", 1);
    @(posedge clk); #1;
    wdata = beat_data[1];
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; wvalid = 1'b0;
    @(negedge clk);
    chk("rst_mid_awready", 128'(awready), 128'(1));
    chk("rst_mid_wready", 128'(wready), 128'(0));
    chk("rst_mid_bvalid", 128'(bvalid), 128'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_b", 128'(bvalid), 128'(0));
    end
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len, size, burst, bad;
    logic [31:0] a;
    rst = 1'b1; awvalid = 1'b0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awid = '0;
    wvalid = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0; bready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", 128'(awready), 128'(1));
    chk("rst_wready", 128'(wready), 128'(0));
    chk("rst_bvalid", 128'(bvalid), 128'(0));
    chk("rst_bid_bresp", 128'({bid, bresp}), 128'(0));
    chk("rst_mem", 128'({mem_we, mem_addr, mem_wdata, mem_be}), 128'(0));
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;

    fill_rand_strb();
    for (int i = 0; i < 16; i++) beat_strb[i] = 8'hFF;
    do_burst(32'h100, 3, 3, 1, 5, -1, 1'b0);
    do_burst(32'h103, 2, 1, 1, 2, -1, 1'b0);
    fill_rand_strb();
    beat_strb[0] = 8'hFF; beat_strb[1] = 8'h0C; beat_strb[2] = 8'hF0;
    do_burst(32'h208, 2, 2, 0, 7, -1, 1'b0);
    fill_rand_strb();
    do_burst(32'h040, 0, 4, 1, 3, -1, 1'b0);
    do_burst(32'h400, 3, 3, 1, 11, 1, 1'b0);
    reset_mid_burst();
    fill_rand_strb();
    do_burst(32'h118, 3, 3, 2, 6, -1, 1'b0);
    do_burst(32'h118, 2, 3, 2, 4, -1, 1'b0);
    do_burst(32'h080, 1, 2, 3, 1, -1, 1'b0);
    do_burst(32'hFFFF_FFF9, 3, 2, 1, 12, -1, 1'b1);

    for (int n = 0; n < 40; n++) begin
      fill_rand_strb();
      a     = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFC0 | 32'($urandom_range(0, 63))) : $urandom;
      size  = ($urandom_range(0, 9) == 0) ? 4 : $urandom_range(0, 3);
      burst = ($urandom_range(0, 11) == 0) ? 3 : $urandom_range(0, 2);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (2 << $urandom_range(0, 3)) - 1;
      else len = $urandom_range(0, 15);
      bad   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, len) : -1;
      do_burst(a, len, size, burst, $urandom_range(0, 15), bad, 1'b1);
    end

    repeat (4) @(negedge clk);
    chk("mem_q_drained", 128'(exp_q.size()), 128'(0));
    chk("b_q_drained", 128'(exp_b_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
